// File: rtl/score_argmax_unit.sv
// Sequential argmax / top-2 engine: scans one snapshotted score per clock and reports winner,
// runner-up and margin. Define ARGMAX_HYST_EN to add hysteresis on Stable_idx.
module score_argmax_unit #(
  parameter int unsigned N_CLASSES   = 10,
  parameter int unsigned W           = 16,
  parameter int unsigned SIGNED_MODE = 0,
  parameter int unsigned HOLD_FRAMES = 3,
  localparam int unsigned IW         = $clog2(N_CLASSES)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [N_CLASSES*W-1:0] Scores,
  output logic                   Ready,
  output logic                   Done,
  output logic [IW-1:0]          Argmax,
  output logic [W-1:0]           Max_score,
  output logic [IW-1:0]          Second_idx,
  output logic [W-1:0]           Second_score,
  output logic [W:0]             Margin,
  output logic [IW-1:0]          Stable_idx
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic Sgn = (SIGNED_MODE != 0);

  state_e        state_q, state_d;
  logic [W-1:0]  snap_q [N_CLASSES];
  logic [IW-1:0] idx_q;
  logic [IW-1:0] best_idx_q, best_idx_d, sec_idx_q, sec_idx_d;
  logic [W-1:0]  best_q, best_d, sec_q, sec_d;
  logic          sec_valid_q;
  logic [W-1:0]  cur;
  logic          last;
  logic          load_result;
  logic [W:0]    margin_d;

  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (Sgn) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign cur         = snap_q[idx_q];
  assign last        = (idx_q == IW'(N_CLASSES - 1));
  assign load_result = (state_q == StScan) && last;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StScan;
      StScan:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    Ready = (state_q == StIdle);
    Done  = (state_q == StDone);
  end

  // Strict > keeps the lowest index on ties; an equal value falls through to runner-up.
  always_comb begin
    best_idx_d = best_idx_q;
    best_d     = best_q;
    sec_idx_d  = sec_idx_q;
    sec_d      = sec_q;
    if (gt(cur, best_q)) begin
      sec_idx_d  = best_idx_q;
      sec_d      = best_q;
      best_idx_d = idx_q;
      best_d     = cur;
    end else if (!sec_valid_q || gt(cur, sec_q)) begin
      sec_idx_d = idx_q;
      sec_d     = cur;
    end
  end

  // One extra bit (sign-extended in signed mode) so best - second never wraps.
  assign margin_d = {best_d[W-1] & Sgn, best_d} - {sec_d[W-1] & Sgn, sec_d};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(N_CLASSES); i++) snap_q[i] <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_q      <= '0;
      sec_idx_q   <= '0;
      sec_q       <= '0;
      sec_valid_q <= 1'b0;
    end else if (state_q == StIdle && Start) begin
      for (int i = 0; i < int'(N_CLASSES); i++) snap_q[i] <= Scores[i*W +: W];
      idx_q       <= IW'(1);
      best_idx_q  <= '0;
      best_q      <= Scores[W-1:0];
      sec_valid_q <= 1'b0;
    end else if (state_q == StScan) begin
      idx_q       <= idx_q + 1'b1;
      best_idx_q  <= best_idx_d;
      best_q      <= best_d;
      sec_idx_q   <= sec_idx_d;
      sec_q       <= sec_d;
      sec_valid_q <= 1'b1;
    end
  end

  // Result registers load on the final compare so they are valid while Done is high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Argmax       <= '0;
      Max_score    <= '0;
      Second_idx   <= '0;
      Second_score <= '0;
      Margin       <= '0;
    end else if (load_result) begin
      Argmax       <= best_idx_d;
      Max_score    <= best_d;
      Second_idx   <= sec_idx_d;
      Second_score <= sec_d;
      Margin       <= margin_d;
    end
  end

`ifdef ARGMAX_HYST_EN
  localparam int unsigned CW = $clog2(HOLD_FRAMES + 1);

  logic [CW-1:0] hold_q;
  logic [CW-1:0] run;

  // Argmax still holds the previous result here, so it marks the running candidate.
  always_comb begin
    if (best_idx_d == Stable_idx) run = '0;
    else if (best_idx_d == Argmax && hold_q != '0) run = hold_q + 1'b1;
    else run = CW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_q     <= '0;
      Stable_idx <= '0;
    end else if (load_result) begin
      if (32'(run) >= HOLD_FRAMES) begin
        Stable_idx <= best_idx_d;
        hold_q     <= '0;
      end else begin
        hold_q <= run;
      end
    end
  end
`else
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)            Stable_idx <= '0;
    else if (load_result) Stable_idx <= best_idx_d;
  end
`endif

endmodule

// File: tb/tb_score_argmax_unit.sv
// Scoreboard bench for score_argmax_unit: an unsigned and a signed instance run in lockstep
// against a behavioural top-2 model.
module tb_score_argmax_unit;

  localparam int unsigned N       = 10;
  localparam int unsigned W       = 16;
  localparam int unsigned IW      = 4;
  localparam int unsigned HOLD    = 3;
  localparam int          MaxWait = 64;

  typedef struct packed {
    logic [31:0]        cyc;
    logic [1:0][IW-1:0] am;
    logic [1:0][W-1:0]  ms;
    logic [1:0][IW-1:0] si;
    logic [1:0][W-1:0]  ss;
    logic [1:0][W:0]    mg;
    logic [1:0][IW-1:0] st;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [N*W-1:0]     scores;
  logic [1:0]         ready, done;
  logic [1:0][IW-1:0] argmax, second_idx, stable_idx;
  logic [1:0][W-1:0]  max_score, second_score;
  logic [1:0][W:0]    margin;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   stable_m [2];
  int   hist0[$];
  int   hist1[$];

  score_argmax_unit #(.N_CLASSES(N), .W(W), .SIGNED_MODE(0), .HOLD_FRAMES(HOLD)) u_dut_u (
    .Clk(clk), .Reset(rst), .Start(start), .Scores(scores),
    .Ready(ready[0]), .Done(done[0]), .Argmax(argmax[0]), .Max_score(max_score[0]),
    .Second_idx(second_idx[0]), .Second_score(second_score[0]), .Margin(margin[0]),
    .Stable_idx(stable_idx[0])
  );

  score_argmax_unit #(.N_CLASSES(N), .W(W), .SIGNED_MODE(1), .HOLD_FRAMES(HOLD)) u_dut_s (
    .Clk(clk), .Reset(rst), .Start(start), .Scores(scores),
    .Ready(ready[1]), .Done(done[1]), .Argmax(argmax[1]), .Max_score(max_score[1]),
    .Second_idx(second_idx[1]), .Second_score(second_score[1]), .Margin(margin[1]),
    .Stable_idx(stable_idx[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Winner = earliest maximum; runner-up = earliest maximum among the remaining classes.
  function automatic void ref_model(input logic [N*W-1:0] s, input bit sgn,
                                    output int bi, output int si, output int diff);
    int v [N];
    for (int i = 0; i < int'(N); i++)
      v[i] = sgn ? int'($signed(s[i*W +: W])) : int'(s[i*W +: W]);
    bi = 0;
    for (int i = 1; i < int'(N); i++) if (v[i] > v[bi]) bi = i;
    si = -1;
    for (int i = 0; i < int'(N); i++)
      if (i != bi && (si < 0 || v[i] > v[si])) si = i;
    diff = v[bi] - v[si];
  endfunction

  // Display index moves once the last HOLD results all agree and differ from it.
  function automatic int next_stable(input int stable, input int hist_in[$], input int a,
                                     output int hist_out[$]);
    int h[$];
    bit agree;
    h = hist_in;
    h.push_back(a);
    if (h.size() > int'(HOLD)) void'(h.pop_front());
    agree = (h.size() == int'(HOLD)) && (a != stable);
    foreach (h[k]) if (h[k] != a) agree = 1'b0;
    if (agree) begin
      stable = a;
      h.delete();
    end
    hist_out = h;
    return stable;
  endfunction

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no response within %0d cycles, required one", name, MaxWait);
  endtask

  task automatic issue(input logic [N*W-1:0] s);
    exp_t e;
    int   w, bi, si, diff;
    w = 0;
    while (!(ready[0] && ready[1]) && w < MaxWait) begin
      @(negedge clk);
      w++;
    end
    if (w >= MaxWait) timeout_fail("ready_wait");
    for (int d = 0; d < 2; d++) begin
      ref_model(s, d == 1, bi, si, diff);
      e.am[d] = IW'(bi);
      e.ms[d] = s[bi*W +: W];
      e.si[d] = IW'(si);
      e.ss[d] = s[si*W +: W];
      e.mg[d] = (W+1)'(diff);
`ifdef ARGMAX_HYST_EN
      if (d == 0) stable_m[0] = next_stable(stable_m[0], hist0, bi, hist0);
      else        stable_m[1] = next_stable(stable_m[1], hist1, bi, hist1);
`else
      stable_m[d] = bi;
`endif
      e.st[d] = IW'(stable_m[d]);
    end
    e.cyc  = cyc;
    sb.push_back(e);
    scores = s;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(ready[0] && ready[1] && sb.size() == 0) && w < MaxWait) begin
      @(negedge clk);
      w++;
    end
    if (w >= MaxWait) timeout_fail("idle_wait");
  endtask

  task automatic check_cleared(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_ready[%0d]", tag, d), ready[d], 1);
      check($sformatf("%s_done[%0d]", tag, d), done[d], 0);
      check($sformatf("%s_argmax[%0d]", tag, d), argmax[d], 0);
      check($sformatf("%s_max[%0d]", tag, d), max_score[d], 0);
      check($sformatf("%s_second[%0d]", tag, d), second_idx[d], 0);
      check($sformatf("%s_second_score[%0d]", tag, d), second_score[d], 0);
      check($sformatf("%s_margin[%0d]", tag, d), margin[d], 0);
      check($sformatf("%s_stable[%0d]", tag, d), stable_idx[d], 0);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    stable_m[0] = 0;
    stable_m[1] = 0;
    hist0.delete();
    hist1.delete();
  endtask

  function automatic logic [N*W-1:0] rand_scores(input int mode);
    logic [N*W-1:0] s;
    logic [W-1:0]   pick [4];
    pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'hFFFF; pick[3] = 16'h0000;
    for (int i = 0; i < int'(N); i++) begin
      case (mode)
        0:       s[i*W +: W] = W'($urandom);
        1:       s[i*W +: W] = W'($urandom_range(0, 3));
        default: s[i*W +: W] = pick[$urandom_range(0, 3)];
      endcase
    end
    return s;
  endfunction

  function automatic logic [N*W-1:0] peak_at(input int k);
    logic [N*W-1:0] s;
    for (int i = 0; i < int'(N); i++) s[i*W +: W] = W'($urandom_range(0, 16'h6FFF));
    s[k*W +: W] = 16'h7000;
    return s;
  endfunction

  // Monitor: every Done pops one expected result.
  always @(negedge clk) begin
    if (!rst && (done[0] || done[1])) begin
      check("done_align", done[1], done[0]);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d, required no pending result", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("latency", cyc, mon_e.cyc + N);
        for (int d = 0; d < 2; d++) begin
          check($sformatf("argmax[%0d]", d), argmax[d], mon_e.am[d]);
          check($sformatf("max_score[%0d]", d), max_score[d], mon_e.ms[d]);
          check($sformatf("second_idx[%0d]", d), second_idx[d], mon_e.si[d]);
          check($sformatf("second_score[%0d]", d), second_score[d], mon_e.ss[d]);
          check($sformatf("margin[%0d]", d), margin[d], mon_e.mg[d]);
          check($sformatf("stable_idx[%0d]", d), stable_idx[d], mon_e.st[d]);
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] s;
    rst    = 1'b1;
    start  = 1'b0;
    scores = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_cleared("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_cleared("after_reset");

    s = '0;
    s[0*W +: W] = 16'h0100;
    s[1*W +: W] = 16'h0F00;
    s[2*W +: W] = 16'h0200;
    issue(s);
    wait_idle();
    check("t1_argmax", argmax[0], 1);
    check("t1_max", max_score[0], 16'h0F00);
    check("t1_second", second_idx[0], 2);
    check("t1_margin", margin[0], 17'h00D00);

    for (int i = 0; i < int'(N); i++) s[i*W +: W] = 16'h0500;
    issue(s);
    wait_idle();
    check("t2_argmax", argmax[0], 0);
    check("t2_second", second_idx[0], 1);
    check("t2_margin", margin[0], 0);

    for (int i = 0; i < int'(N); i++) s[i*W +: W] = 16'hFFFF;
    s[3*W +: W] = 16'h7FFF;
    s[7*W +: W] = 16'h8000;
    issue(s);
    wait_idle();
    check("t3_argmax", argmax[1], 3);
    check("t3_second", second_idx[1], 0);
    check("t3_margin", margin[1], 17'h08000);

    // Scores and Start toggled during the scan must not disturb the result.
    issue(rand_scores(0));
    for (int c = 0; c < 7; c++) begin
      check("busy_ready", ready[0], 0);
      scores = rand_scores(0);
      start  = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a scan: no Done, outputs back to zero.
    issue(rand_scores(0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("mid_scan_reset");
    repeat (N + 2) @(negedge clk);
    issue(rand_scores(0));
    wait_idle();

    // Argmax sequence 4,4,7,7,7 starting from a freshly reset display index.
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(peak_at(4));
    issue(peak_at(4));
    wait_idle();
`ifdef ARGMAX_HYST_EN
    check("t6_stable_after_2", stable_idx[0], 0);
`else
    check("t6_stable_after_2", stable_idx[0], 4);
`endif
    issue(peak_at(7));
    issue(peak_at(7));
    issue(peak_at(7));
    wait_idle();
    check("t6_stable_after_5", stable_idx[0], 7);

    for (int k = 0; k < 60; k++) issue(rand_scores(int'($urandom_range(0, 2))));
    wait_idle();
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
